ov7725_flash_reader: RTL
========================

// Module: ov7725_flash_reader
// PURPOSE
//  Read back a grey-scale frame that the camera flash writer has stored in SPI NOR flash.
//  Frame layout: byte address = BASE_ADDR + col + row*IMG_W, one byte per pixel.
//  Block is its own SPI mode-0 master, using READ command 0x03 in fixed-size bursts.
//  Output is a row-major pixel stream with valid/ready handshake and SOF/EOL markers.
//  Sits between the flash pins and the display/UART path; never shares the bus with the writer.
// PARAMETERS
//  IMG_W      640     pixels per row
//  IMG_H      480     rows per frame
//  BASE_ADDR  24'h0   flash address of pixel (0,0)
//  BURST      64      max bytes per 0x03 command (>=1); last burst is shortened to what remains
//  CS_GAP     4       min clk24M cycles cs stays high between bursts
//  FIFO_D     4       output FIFO depth (power of 2)
// PORTS
//  clk24M     in   1   sole clock; all logic on posedge
//  rst_n      in   1   asynchronous active-low reset
//  start      in   1   frame read request; acted on at rising edge (internally registered)
//  sck        out  1   SPI clock = clk24M/2 while shifting; idle low
//  cs         out  1   flash chip select, active low
//  mosi       out  1   SPI data to flash
//  miso       in   1   SPI data from flash
//  pix_data   out  8   pixel byte (FIFO head)
//  pix_valid  out  1   pix_data valid
//  pix_ready  in   1   consumer accepts when pix_valid & pix_ready
//  pix_sof    out  1   qualifies pix_data: pixel (0,0)
//  pix_eol    out  1   qualifies pix_data: col==IMG_W-1
//  busy       out  1   high from accepted start until frame_done
//  frame_done out  1   one-cycle pulse after last pixel of frame is popped
// BEHAVIOUR
//  Reset values: sck=0, cs=1, mosi=0, pix_valid=0, pix_sof=0, pix_eol=0, busy=0, frame_done=0.
//  Reset also clears the FIFO and all counters; start edge detector resets to 0.
//  Reset asserted mid-burst: cs goes high and sck goes low asynchronously; no partial pixel is emitted.
//  FSM states:
//   IDLE: on start rise -> CS_SETUP; addr=BASE_ADDR; busy=1.
//   CS_SETUP: cs=0 for 1 cycle -> CMD.
//   CMD: shift 8'h03, MSB first -> ADDR.
//   ADDR: shift 24-bit addr, MSB first -> DATA.
//   DATA: receive n = min(BURST, remaining) bytes -> CS_HIGH.
//   CS_HIGH: cs=1 for CS_GAP cycles; addr += n. If remaining>0 -> CS_SETUP, else -> DRAIN.
//   DRAIN: wait for FIFO empty; pulse frame_done; busy=0 -> IDLE.
//  Bit timing: each bit takes 2 cycles.
//   Phase A: sck=0, mosi=bit.
//   Phase B: sck=1; miso is sampled at the posedge that ends phase B.
//   mosi=0 during DATA.
//  Backpressure: a data byte starts only if FIFO count + in-flight < FIFO_D.
//   Otherwise sck holds low with cs low (pause between bytes only, never mid-byte).
//  A byte is pushed to the FIFO the cycle after its 8th bit is sampled.
//  Bit order: MSB first.
//  Pixel counters col/row (10-bit each) advance on each pop.
//   col wraps IMG_W-1 -> 0 and increments row.
//   After pixel (IMG_W-1, IMG_H-1), both counters clear.
//  pix_sof/pix_eol are derived from the pop-side counters, not the flash side.
//  remaining: 24-bit down-counter preset to IMG_W*IMG_H; decrements by n per burst.
//  start rises while busy: ignored (no restart, no queueing).
//  Simultaneous FIFO push and pop: count is unchanged.
//  FIFO full: no push can occur, guaranteed by the start rule above.
//  Latency: first pix_valid = 2+16+48+16+1 = 83 cycles after the start edge is registered (no stall).
// TESTING
//  T1 reset: hold rst_n=0 -> cs=1, sck=0, busy=0, pix_valid=0; release -> outputs unchanged until start.
//  T2 small frame, IMG_W=4, IMG_H=2, BURST=3, flash model returns addr[7:0]:
//   -> bursts at 0x000000/3, 0x000003/3, 0x000006/2.
//   -> stream 00..07; sof on 00; eol on 03 and 07; one frame_done pulse.
//  T3 serial check: capture mosi on sck rise -> 0x03, then BASE_ADDR=24'h012345 bytes 01 23 45, MSB first.
//  T4 backpressure: pix_ready=0 for 50 cycles mid-burst -> exactly FIFO_D bytes buffered.
//   -> sck stays low, cs stays low, no data lost; stream resumes in order.
//  T5 start pulse while busy -> ignored; the frame completes once with exactly IMG_W*IMG_H pixels.
//  T6 rst_n low in middle of DATA -> cs=1 immediately; after release, a new start reads the frame from (0,0).

Source files
------------

// File: rtl/ov7725_flash_reader.sv
// ov7725_flash_reader: reads a stored grey-scale frame back from SPI NOR
// flash with READ 0x03 bursts and streams it row-major with SOF/EOL.
module ov7725_flash_reader #(
  parameter int          IMG_W     = 640,
  parameter int          IMG_H     = 480,
  parameter logic [23:0] BASE_ADDR = 24'h0,
  parameter int          BURST     = 64,
  parameter int          CS_GAP    = 4,
  parameter int          FIFO_D    = 4
) (
  input  logic       clk24M,
  input  logic       rst_n,
  input  logic       start,
  output logic       sck,
  output logic       cs,
  output logic       mosi,
  input  logic       miso,
  output logic [7:0] pix_data,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       pix_sof,
  output logic       pix_eol,
  output logic       busy,
  output logic       frame_done
);

  localparam int          AW       = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam logic [23:0] FRAME    = 24'(IMG_W * IMG_H);
  localparam logic [23:0] BURST_N  = 24'(BURST);
  localparam logic [7:0]  GAP_LAST = 8'(CS_GAP - 1);
  localparam logic [9:0]  COL_LAST = 10'(IMG_W - 1);
  localparam logic [9:0]  ROW_LAST = 10'(IMG_H - 1);
  localparam logic [AW:0] DEPTH    = FIFO_D[AW:0];
  localparam logic [AW:0] CNT1     = 1;
  localparam logic [AW-1:0] PTR1   = 1;

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, CMD, ADDR, DATA, CS_HIGH, DRAIN
  } state_t;

  state_t      state;
  logic        start_q;
  logic        start_d;
  logic [23:0] addr;
  logic [23:0] remaining;
  logic [23:0] burst_n;
  logic [23:0] burst_left;
  logic [30:0] sh;
  logic [4:0]  bitcnt;
  logic [6:0]  rx;
  logic        push_pend;
  logic [7:0]  push_byte;
  logic [7:0]  gap;

  logic [7:0]    mem [FIFO_D];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [9:0]    col;
  logic [9:0]    row;

  logic          start_rise;
  logic          pop;
  logic [AW+1:0] occ;
  logic          byte_ok;

  assign start_rise = start_q & ~start_d;
  assign pix_valid  = (count != '0);
  assign pop        = pix_valid & pix_ready;
  assign pix_data   = mem[rd_ptr];
  assign pix_sof    = pix_valid & (col == 10'd0) & (row == 10'd0);
  assign pix_eol    = pix_valid & (col == COL_LAST);
  // a byte waiting to be pushed still occupies a FIFO slot
  assign occ     = {1'b0, count} + {{(AW+1){1'b0}}, push_pend};
  assign byte_ok = occ < {1'b0, DEPTH};

  always_ff @(posedge clk24M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sck        <= 1'b0;
      cs         <= 1'b1;
      mosi       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      start_q    <= 1'b0;
      start_d    <= 1'b0;
      addr       <= '0;
      remaining  <= '0;
      burst_n    <= '0;
      burst_left <= '0;
      sh         <= '0;
      bitcnt     <= '0;
      rx         <= '0;
      push_pend  <= 1'b0;
      push_byte  <= '0;
      gap        <= '0;
    end else begin
      start_q    <= start;
      start_d    <= start_q;
      frame_done <= 1'b0;
      push_pend  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_rise) begin
            addr      <= BASE_ADDR;
            remaining <= FRAME;
            busy      <= 1'b1;
            cs        <= 1'b0;
            state     <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          // command bit 7 (0) goes out directly; the rest queues in sh
          sh      <= {7'h03, addr};
          mosi    <= 1'b0;
          sck     <= 1'b0;
          bitcnt  <= '0;
          burst_n <= (remaining > BURST_N) ? BURST_N : remaining;
          burst_left <= (remaining > BURST_N) ? BURST_N : remaining;
          state   <= CMD;
        end
        CMD, ADDR: begin
          if (!sck) begin
            sck <= 1'b1;
          end else begin
            sck    <= 1'b0;
            mosi   <= sh[30];
            sh     <= {sh[29:0], 1'b0};
            bitcnt <= bitcnt + 5'd1;
            if (state == CMD && bitcnt == 5'd7) begin
              bitcnt <= '0;
              state  <= ADDR;
            end else if (state == ADDR && bitcnt == 5'd23) begin
              bitcnt <= '0;
              mosi   <= 1'b0;
              state  <= DATA;
            end
          end
        end
        DATA: begin
          if (!sck) begin
            if (bitcnt != 5'd0 || byte_ok) sck <= 1'b1;
          end else begin
            sck    <= 1'b0;
            rx     <= {rx[5:0], miso};
            bitcnt <= bitcnt + 5'd1;
            if (bitcnt == 5'd7) begin
              bitcnt     <= '0;
              push_pend  <= 1'b1;
              push_byte  <= {rx, miso};
              burst_left <= burst_left - 24'd1;
              if (burst_left == 24'd1) begin
                cs        <= 1'b1;
                gap       <= '0;
                addr      <= addr + burst_n;
                remaining <= remaining - burst_n;
                state     <= CS_HIGH;
              end
            end
          end
        end
        CS_HIGH: begin
          if (gap == GAP_LAST) begin
            if (remaining != 24'd0) begin
              cs    <= 1'b0;
              state <= CS_SETUP;
            end else begin
              state <= DRAIN;
            end
          end else begin
            gap <= gap + 8'd1;
          end
        end
        DRAIN: begin
          if (count == '0 && !push_pend) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk24M) begin
    if (push_pend) mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge clk24M or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      col    <= '0;
      row    <= '0;
    end else begin
      if (push_pend) wr_ptr <= wr_ptr + PTR1;
      if (pop) rd_ptr <= rd_ptr + PTR1;
      if (push_pend && !pop) count <= count + CNT1;
      else if (!push_pend && pop) count <= count - CNT1;
      if (pop) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? 10'd0 : row + 10'd1;
        end else begin
          col <= col + 10'd1;
        end
      end
    end
  end

endmodule
